// File: rtl/mips_pkg.sv
// Shared widths, constants and entry type for the instruction-fetch slice.
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [ADDR_W-1:0]  PC_INCR          = 32'h0000_0004;
    localparam logic [INSTR_W-1:0] NOP              = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

    // Instructions are word aligned; the two low address bits are dropped.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {instr, pc} pairs between the memory response and decode.
module fetch_queue
    import mips_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic [ADDR_W-1:0]  push_pc,
    input  logic               pop,
    input  logic               flush,
    output logic [CNT_W-1:0]   count,
    output logic [INSTR_W-1:0] head_instr,
    output logic [ADDR_W-1:0]  head_pc
);

    fetch_entry_t     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_s;
    logic             push_s;
    logic             pop_s;

    // Guard push/pop against full/empty and compute the next occupancy.
    always_comb begin
        pop_s   = pop & (count_r != {CNT_W{1'b0}});
        push_s  = push & ((count_r < CNT_W'(DEPTH)) | pop_s);
        count_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + CNT_W'(1'b1);
            2'b01:   count_s = count_r - CNT_W'(1'b1);
            default: count_s = count_r;
        endcase
    end

    // Storage, pointers and count; flush empties the queue but keeps the words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{instr: NOP, pc: {ADDR_W{1'b0}}};
            end
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= '{instr: push_instr, pc: push_pc};
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            count_r <= count_s;
        end
    end

    assign count      = count_r;
    assign head_instr = mem_r[rd_ptr_r].instr;
    assign head_pc    = mem_r[rd_ptr_r].pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the 1-cycle synchronous imem,
// buffers returned words and hands them to decode over valid/ready.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int                QUEUE_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] req_pc_r;
    logic              inflight_r;
    logic              kill_r;

    logic [CNT_W-1:0]  count_s;
    logic [OCC_W-1:0]  occ_s;
    logic              instr_valid_s;
    logic              pop_s;
    logic              issue_s;
    logic              push_s;

    // Issue only when the slot for this request's response is guaranteed;
    // rst_n gates the strobe so it drops the instant reset is asserted.
    always_comb begin
        instr_valid_s = (count_s != {CNT_W{1'b0}});
        pop_s         = instr_valid_s & instr_ready;
        occ_s         = {1'b0, count_s} + OCC_W'(inflight_r) - OCC_W'(pop_s);
        issue_s       = rst_n & ~redirect_valid & (occ_s < OCC_W'(QUEUE_DEPTH));
        push_s        = inflight_r & ~kill_r & ~redirect_valid;
    end

    // PC, outstanding-request tracking and redirect kill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r       <= RESET_PC;
            req_pc_r   <= {ADDR_W{1'b0}};
            inflight_r <= 1'b0;
            kill_r     <= 1'b0;
        end else if (redirect_valid) begin
            pc_r       <= align_pc(redirect_pc);
            inflight_r <= 1'b0;
            kill_r     <= inflight_r;
        end else if (issue_s) begin
            pc_r       <= pc_r + PC_INCR;
            req_pc_r   <= pc_r;
            inflight_r <= 1'b1;
            kill_r     <= 1'b0;
        end else begin
            inflight_r <= 1'b0;
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_s),
        .push_instr (imem_rdata),
        .push_pc    (req_pc_r),
        .pop        (pop_s),
        .flush      (redirect_valid),
        .count      (count_s),
        .head_instr (instr),
        .head_pc    (instr_pc)
    );

    assign imem_req    = issue_s;
    assign imem_addr   = pc_r;
    assign instr_valid = instr_valid_s;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table plus randomized run
// against a queue-based reference model.
module tb_fetch_unit;
    import mips_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RPC), .QUEUE_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: delivered words in order, one pending memory response, the PC.
    logic [63:0] mq[$];
    bit          m_pend;
    logic [31:0] m_pend_pc;
    logic [31:0] m_pc;

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          rv;
        logic [31:0] rpc;
        bit          ev;
        logic [31:0] epc;
        bit          ereq;
        logic [31:0] ea;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pend    = 1'b0;
        m_pend_pc = 32'h0;
        m_pc      = RPC;
    endtask

    task automatic add(input bit rst, input bit rdy, input bit rv, input logic [31:0] rpc,
                       input bit ev, input logic [31:0] epc, input bit ereq, input logic [31:0] ea);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.ev = ev; v.epc = epc; v.ereq = ereq; v.ea = ea;
        tbl.push_back(v);
    endtask

    // One clock cycle: drive, sample, compare against the model, advance the model.
    task automatic step(input bit rst, input bit rdy, input bit rv, input logic [31:0] rpc,
                        output logic sv, output logic [31:0] si, output logic [31:0] spc,
                        output logic sr, output logic [31:0] sa);
        bit          e_valid;
        bit          e_req;
        bit          pop;
        int          occ;
        logic [31:0] e_addr;
        logic [63:0] head;
        @(negedge clk);
        rst_n          = !rst;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_rdata     = m_pend ? memf(m_pend_pc) : $urandom;
        #1;
        sv = instr_valid; si = instr; spc = instr_pc; sr = imem_req; sa = imem_addr;
        pop = 1'b0;
        if (rst) begin
            e_valid = 1'b0; e_req = 1'b0; e_addr = RPC;
        end else begin
            e_valid = (mq.size() > 0);
            pop     = e_valid & rdy;
            occ     = mq.size() + int'(m_pend) - int'(pop);
            e_req   = !rv && (occ < DEPTH);
            e_addr  = m_pc;
        end
        chk("model_valid", {31'b0, sv}, {31'b0, e_valid});
        if (e_valid) begin
            head = mq[0];
            chk("model_instr", si, head[63:32]);
            chk("model_pc", spc, head[31:0]);
        end
        chk("model_req", {31'b0, sr}, {31'b0, e_req});
        chk("model_addr", sa, e_addr);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (rv) begin
            mq.delete();
            m_pend = 1'b0;
            m_pc   = {rpc[31:2], 2'b00};
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_pend) mq.push_back({imem_rdata, m_pend_pc});
            m_pend = e_req;
            if (e_req) begin
                m_pend_pc = m_pc;
                m_pc      = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        logic        sv;
        logic        sr;
        logic [31:0] si;
        logic [31:0] spc;
        logic [31:0] sa;
        logic [31:0] rpc;
        vec_t        v;

        rst_n = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; imem_rdata = 32'h0;
        model_reset();

        // Basic streaming from reset
        add(1,1,0,32'h0,   0,32'h0,1'b0,32'h0);
        add(0,1,0,32'h0,   0,32'h0,1'b1,32'h0);
        add(0,1,0,32'h0,   0,32'h0,1'b1,32'h4);
        add(0,1,0,32'h0,   1,32'h0,1'b1,32'h8);
        add(0,1,0,32'h0,   1,32'h4,1'b1,32'hC);
        add(0,1,0,32'h0,   1,32'h8,1'b1,32'h10);
        // Backpressure: reset mid-stream, six cycles of ready=0, then release
        add(1,1,0,32'h0,   0,32'h0,1'b0,32'h0);
        add(0,0,0,32'h0,   0,32'h0,1'b1,32'h0);
        add(0,0,0,32'h0,   0,32'h0,1'b1,32'h4);
        add(0,0,0,32'h0,   1,32'h0,1'b0,32'h8);
        add(0,0,0,32'h0,   1,32'h0,1'b0,32'h8);
        add(0,0,0,32'h0,   1,32'h0,1'b0,32'h8);
        add(0,0,0,32'h0,   1,32'h0,1'b0,32'h8);
        add(0,1,0,32'h0,   1,32'h0,1'b1,32'h8);
        add(0,1,0,32'h0,   1,32'h4,1'b1,32'hC);
        add(0,1,0,32'h0,   1,32'h8,1'b1,32'h10);
        add(0,1,0,32'h0,   1,32'hC,1'b1,32'h14);
        // Redirect while the request for 12 is in flight, then misaligned, then wrap
        add(1,1,0,32'h0,   0,32'h0,1'b0,32'h0);
        add(0,1,0,32'h0,   0,32'h0,1'b1,32'h0);
        add(0,1,0,32'h0,   0,32'h0,1'b1,32'h4);
        add(0,1,0,32'h0,   1,32'h0,1'b1,32'h8);
        add(0,1,0,32'h0,   1,32'h4,1'b1,32'hC);
        add(0,1,1,32'h100, 1,32'h8,1'b0,32'h10);
        add(0,1,0,32'h0,   0,32'h0,1'b1,32'h100);
        add(0,1,0,32'h0,   0,32'h0,1'b1,32'h104);
        add(0,1,0,32'h0,   1,32'h100,1'b1,32'h108);
        add(0,1,1,32'h203, 1,32'h104,1'b0,32'h10C);
        add(0,1,0,32'h0,   0,32'h0,1'b1,32'h200);
        add(0,1,0,32'h0,   0,32'h0,1'b1,32'h204);
        add(0,1,0,32'h0,   1,32'h200,1'b1,32'h208);
        add(0,1,1,32'hFFFF_FFF8, 1,32'h204,1'b0,32'h20C);
        add(0,1,0,32'h0,   0,32'h0,1'b1,32'hFFFF_FFF8);
        add(0,1,0,32'h0,   0,32'h0,1'b1,32'hFFFF_FFFC);
        add(0,1,0,32'h0,   1,32'hFFFF_FFF8,1'b1,32'h0);
        add(0,1,0,32'h0,   1,32'hFFFF_FFFC,1'b1,32'h4);
        add(0,1,0,32'h0,   1,32'h0,1'b1,32'h8);
        add(0,1,0,32'h0,   1,32'h4,1'b1,32'hC);
        // Back-to-back redirects: the last one wins
        add(0,1,1,32'h400, 1,32'h8,1'b0,32'h10);
        add(0,1,1,32'h500, 0,32'h0,1'b0,32'h400);
        add(0,1,0,32'h0,   0,32'h0,1'b1,32'h500);
        add(0,0,0,32'h0,   0,32'h0,1'b1,32'h504);
        add(0,0,0,32'h0,   1,32'h500,1'b0,32'h508);

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            step(v.rst, v.rdy, v.rv, v.rpc, sv, si, spc, sr, sa);
            chk($sformatf("tbl%0d_valid", i), {31'b0, sv}, {31'b0, v.ev});
            if (v.ev) begin
                chk($sformatf("tbl%0d_pc", i), spc, v.epc);
                chk($sformatf("tbl%0d_instr", i), si, memf(v.epc));
            end
            chk($sformatf("tbl%0d_req", i), {31'b0, sr}, {31'b0, v.ereq});
            chk($sformatf("tbl%0d_addr", i), sa, v.ea);
        end

        // Asynchronous reset between clock edges while streaming
        for (int i = 0; i < 3; i++) step(0, 1, 0, 32'h0, sv, si, spc, sr, sa);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("async_rst_req", {31'b0, imem_req}, 32'h0);
        chk("async_rst_addr", imem_addr, RPC);
        model_reset();
        step(1, 1, 0, 32'h0, sv, si, spc, sr, sa);
        step(0, 1, 0, 32'h0, sv, si, spc, sr, sa);
        chk("restart_req", {31'b0, sr}, 32'h1);
        chk("restart_addr", sa, RPC);
        step(0, 1, 0, 32'h0, sv, si, spc, sr, sa);
        chk("restart_no_stale", {31'b0, sv}, 32'h0);
        step(0, 1, 0, 32'h0, sv, si, spc, sr, sa);
        chk("restart_first_valid", {31'b0, sv}, 32'h1);
        chk("restart_first_pc", spc, RPC);

        // Randomized run against the reference model
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 2))
                0:       rpc = $urandom;
                1:       rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                default: rpc = 32'($urandom_range(0, 255));
            endcase
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 11) == 0, rpc, sv, si, spc, sr, sa);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
